// File: rtl/demux_pkg.sv
// Shared sizing and state encoding for the 1:16 serial-to-parallel demux.
package demux_pkg;

    localparam int unsigned N     = 16;
    localparam int unsigned SEL_W = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

endpackage

// File: rtl/demux_1x16_deser_if.sv
// Serial input / parallel output bundle of the 1:16 demux deserializer.
interface demux_1x16_deser_if;
    import demux_pkg::*;

    logic               clear;
    logic               auto_mode;
    logic               din;
    logic               din_valid;
    logic [SEL_W-1:0]   sel;
    logic [N-1:0]       dout;
    logic               dout_valid;
    logic [N-1:0]       fill_mask;
    logic               busy;
    logic               overrun;

    modport master (
        output clear, auto_mode, din, din_valid, sel,
        input  dout, dout_valid, fill_mask, busy, overrun
    );

    modport slave (
        input  clear, auto_mode, din, din_valid, sel,
        output dout, dout_valid, fill_mask, busy, overrun
    );

endinterface

// File: rtl/demux_1x16_dec.sv
// One-hot slot write-enable decoder; a clear in the same cycle suppresses the write.
module demux_1x16_dec
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0] idx,
    input  logic             din_valid,
    input  logic             clear,
    output logic [N-1:0]     we_c
);

    always_comb begin
        we_c = '0;
        if (din_valid && !clear) begin
            we_c = N'(1) << idx;
        end
    end

endmodule

// File: rtl/demux_1x16_deser.sv
// Rebuilds a 16-bit word from a select-tagged (or auto-indexed) serial bit stream.
module demux_1x16_deser
    import demux_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    demux_1x16_deser_if.slave    bus
);

    state_e             state_q, state_d;
    logic               mode_q, mode_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [N-1:0]       shadow_q, shadow_d;
    logic [N-1:0]       mask_q, mask_d;
    logic [N-1:0]       dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               overrun_q, overrun_d;
    logic               busy_q, busy_d;

    logic               mode_c;
    logic [SEL_W-1:0]   idx_c;
    logic [N-1:0]       we_c;
    logic [N-1:0]       mask_new_c;

    // Mode is only latched at frame start; idle frames follow the live input.
    assign mode_c = (state_q == IDLE) ? bus.auto_mode : mode_q;
    assign idx_c  = mode_c ? ptr_q : bus.sel;

    demux_1x16_dec u_dec (
        .idx       (idx_c),
        .din_valid (bus.din_valid),
        .clear     (bus.clear),
        .we_c      (we_c)
    );

    assign mask_new_c = mask_q | we_c;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        ptr_d        = ptr_q;
        shadow_d     = shadow_q;
        mask_d       = mask_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        overrun_d    = 1'b0;

        if (bus.clear) begin
            mask_d  = '0;
            ptr_d   = '0;
            state_d = IDLE;
        end else if (bus.din_valid) begin
            shadow_d  = (shadow_q & ~we_c) | (we_c & {N{bus.din}});
            overrun_d = |(mask_q & we_c);
            if (state_q == IDLE) begin
                mode_d = bus.auto_mode;
            end
            state_d = FILL;
            if (mode_c) begin
                ptr_d = ptr_q + SEL_W'(1);
            end
            // Completing write: publish the merged word and start a fresh frame.
            if (&mask_new_c) begin
                dout_d       = shadow_d;
                dout_valid_d = 1'b1;
                mask_d       = '0;
                ptr_d        = '0;
                state_d      = IDLE;
            end else begin
                mask_d = mask_new_c;
            end
        end

        busy_d = (state_d == FILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            ptr_q        <= '0;
            shadow_q     <= '0;
            mask_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            ptr_q        <= ptr_d;
            shadow_q     <= shadow_d;
            mask_q       <= mask_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.fill_mask  = mask_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_demux_1x16_deser.sv
// Bench for demux_1x16_deser: directed scenarios plus random traffic against a frame-level model.
module tb_demux_1x16_deser;
    import demux_pkg::*;

    logic clk;
    logic rst_n;

    demux_1x16_deser_if bus ();

    demux_1x16_deser dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    int dv_seen;
    int ovr_seen;

    // Frame-level reference: which slots hold data, and what they hold.
    bit [15:0] m_filled;
    bit [15:0] m_data;
    bit        m_in_frame;
    bit        m_auto;
    int        m_next;
    bit [15:0] m_dout;
    bit        m_dv;
    bit        m_ovr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_filled   = '0;
        m_data     = '0;
        m_in_frame = 1'b0;
        m_auto     = 1'b0;
        m_next     = 0;
        m_dout     = '0;
        m_dv       = 1'b0;
        m_ovr      = 1'b0;
    endfunction

    function automatic void model_step(bit v, bit d, int s, bit am, bit clr);
        int slot;
        m_dv  = 1'b0;
        m_ovr = 1'b0;
        if (clr) begin
            m_filled   = '0;
            m_next     = 0;
            m_in_frame = 1'b0;
        end else if (v) begin
            if (!m_in_frame) begin
                m_in_frame = 1'b1;
                m_auto     = am;
            end
            slot = m_auto ? m_next : s;
            if (m_filled[slot]) m_ovr = 1'b1;
            m_data[slot]   = d;
            m_filled[slot] = 1'b1;
            if (m_auto) m_next = (m_next + 1) % 16;
            if ($countones(m_filled) == 16) begin
                m_dout     = m_data;
                m_dv       = 1'b1;
                m_filled   = '0;
                m_next     = 0;
                m_in_frame = 1'b0;
            end
        end
    endfunction

    task automatic check_outputs();
        chk("dout",       32'(bus.dout),       32'(m_dout));
        chk("dout_valid", 32'(bus.dout_valid), 32'(m_dv));
        chk("fill_mask",  32'(bus.fill_mask),  32'(m_filled));
        chk("busy",       32'(bus.busy),       32'(m_in_frame));
        chk("overrun",    32'(bus.overrun),    32'(m_ovr));
        if (bus.dout_valid === 1'b1) dv_seen++;
        if (bus.overrun === 1'b1) ovr_seen++;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, compare after it.
    task automatic cyc(input bit v, input bit d, input int s, input bit am, input bit clr);
        bus.din_valid = v;
        bus.din       = d;
        bus.sel       = SEL_W'(s);
        bus.auto_mode = am;
        bus.clear     = clr;
        @(posedge clk);
        model_step(v, d, s, am, clr);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic send_manual(input logic [15:0] w, input int max_gap);
        for (int k = 0; k < 16; k++) begin
            if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
            cyc(1'b1, w[k], k, 1'b0, 1'b0);
        end
    endtask

    task automatic send_auto(input logic [15:0] w);
        for (int k = 0; k < 16; k++) cyc(1'b1, w[k], int'($urandom_range(15, 0)), 1'b1, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        dv_seen = 0;
        ovr_seen = 0;
        model_reset();
        rst_n         = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = 1'b0;
        bus.sel       = '0;
        bus.auto_mode = 1'b0;
        bus.clear     = 1'b0;
        #12;
        check_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Manual sweep of 5555; pulse lands one clock after the sel=15 write.
        dv_seen = 0;
        send_manual(16'h5555, 0);
        chk("t1_dout", 32'(bus.dout), 32'h5555);
        idle(3);
        chk("t1_dv_count", 32'(dv_seen), 32'd1);

        // Auto mode, two back-to-back words; select bus is noise.
        dv_seen = 0;
        send_auto(16'hA5C3);
        chk("t2_dout_a", 32'(bus.dout), 32'hA5C3);
        send_auto(16'h0FF0);
        chk("t2_dout_b", 32'(bus.dout), 32'h0FF0);
        chk("t2_mask_idle", 32'(bus.fill_mask), 32'h0);
        idle(2);
        chk("t2_dv_count", 32'(dv_seen), 32'd2);

        // Duplicate write to slot 7 with a 0 bit.
        ovr_seen = 0;
        for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, k, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 7, 1'b0, 1'b0);
        for (int k = 8; k < 16; k++) cyc(1'b1, 1'b1, k, 1'b0, 1'b0);
        chk("t3_dout", 32'(bus.dout), 32'hFF7F);
        idle(2);
        chk("t3_ovr_count", 32'(ovr_seen), 32'd1);

        // Clear mid-frame wins over a simultaneous valid bit.
        for (int k = 0; k < 9; k++) cyc(1'b1, 1'b0, k, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 9, 1'b0, 1'b1);
        chk("t4_mask", 32'(bus.fill_mask), 32'h0);
        chk("t4_busy", 32'(bus.busy), 32'h0);
        chk("t4_dout_held", 32'(bus.dout), 32'hFF7F);
        send_manual(16'h3C96, 0);
        chk("t4_dout_new", 32'(bus.dout), 32'h3C96);

        // Asynchronous reset mid-frame.
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, k, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_dout", 32'(bus.dout), 32'h0);
        chk("t5_mask", 32'(bus.fill_mask), 32'h0);
        chk("t5_busy", 32'(bus.busy), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        dv_seen = 0;
        idle(20);
        chk("t5_no_stale_dv", 32'(dv_seen), 32'd0);

        // Sparse sweep with random gaps.
        dv_seen = 0;
        ovr_seen = 0;
        send_manual(16'h5555, 3);
        idle(3);
        chk("t6_dout", 32'(bus.dout), 32'h5555);
        chk("t6_dv_count", 32'(dv_seen), 32'd1);
        chk("t6_ovr_count", 32'(ovr_seen), 32'd0);

        // Random traffic: mode flips, gaps, duplicates, occasional clear.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(99, 0) < 70) ? 1'b1 : 1'b0,
                1'($urandom),
                int'($urandom_range(15, 0)),
                ($urandom_range(99, 0) < 50) ? 1'b1 : 1'b0,
                ($urandom_range(99, 0) < 2) ? 1'b1 : 1'b0);
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
